cordic_seq: RTL
===============

// Module: cordic_seq
// PURPOSE
//   Iteration sequencer and result capture around the 16-bit cordic datapath.
//   Accepts a target angle on a valid/ready handshake and drives cordic
//   endangle/load/addr for one load cycle plus ITERS iteration cycles.
//   Then captures the cordic sin/cos outputs into held result registers and
//   presents them on a valid/ready output handshake.
// PARAMETERS
//   WIDTH  16  data width of angle, sin, cos
//   ITERS  16  CORDIC iterations per operation; must be <= 2**ADDRW
//   ADDRW  4   width of cordic addr (arctan ROM index)
// PORTS
//   clock        in   1      single clock, all state updates on rising edge
//   reset        in   1      synchronous, active-high reset
//   in_valid     in   1      start request; angle valid
//   in_angle     in   WIDTH  target angle, same format as cordic endangle
//   in_ready     out  1      high only in IDLE; start accepted when in_valid&&in_ready
//   cor_endangle out  WIDTH  to cordic endangle; registered copy of accepted in_angle
//   cor_load     out  1      to cordic load; high for exactly one cycle per operation
//   cor_addr     out  ADDRW  to cordic addr; iteration index / ROM address
//   cor_sin      in   WIDTH  from cordic sin
//   cor_cos      in   WIDTH  from cordic cos
//   out_valid    out  1      result valid; held until accepted
//   out_sin      out  WIDTH  captured sin result
//   out_cos      out  WIDTH  captured cos result
//   out_ready    in   1      consumer accepts result when out_valid&&out_ready
//   busy         out  1      high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; busy=0; cor_load=0; cor_addr=0;
//     cor_endangle=0; out_valid=0; out_sin=0; out_cos=0.
//   Reset dominates every other input; reset mid-operation abandons it, no result.
//   States: IDLE -> LOAD -> ITER -> CAPT -> DONE -> IDLE.
//   IDLE: in_ready=1. If in_valid, register in_angle into cor_endangle; go LOAD.
//     in_valid without in_ready is ignored (no queuing).
//   LOAD: one cycle; cor_load=1, cor_addr=0. Next state ITER, iteration counter=0.
//   ITER: cor_load=0; cor_addr=counter. Counter increments once per cycle.
//     Leave to CAPT after the cycle with counter==ITERS-1: exactly ITERS cycles.
//   CAPT: one cycle, cor_addr holds ITERS-1. At its closing edge register
//     cor_sin/cor_cos into out_sin/out_cos, set out_valid=1, go DONE.
//   DONE: out_valid=1, outputs stable. On out_valid&&out_ready clear out_valid,
//     go IDLE. Result registers keep their last value after acceptance.
//   in_ready is low in DONE; a new start is taken only from IDLE, earliest the
//     cycle after the output handshake.
//   cor_endangle is held constant from acceptance until the next acceptance.
//   Latency: accept edge = edge 0; out_valid first seen high after edge ITERS+2
//     (18 for default). Throughput with out_ready tied high: one result every
//     ITERS+4 cycles (IDLE cycle, LOAD, ITERS ITER cycles, CAPT, DONE cycle).
//   Counter width ADDRW+1, so ITERS == 2**ADDRW never wraps before compare.
//   No arithmetic on angle/sin/cos; values pass through bit-exact.
// TESTING
//   1 reset: hold reset 3 cycles -> all outputs at reset values, in_ready=1.
//   2 single op: in_angle=16'h2000 pulse -> cor_load 1 cycle, cor_addr 0..15
//     over 16 cycles, out_valid at edge 18, out_sin/out_cos = cordic values.
//   3 backpressure: out_ready=0 for 10 cycles -> out_valid, out_sin, out_cos
//     stable, in_ready=0; in_valid pulses ignored; out_ready=1 -> IDLE next.
//   4 back-to-back: in_valid and out_ready held high, angles 0, 16'h4000 ->
//     results in order, 20-cycle spacing, cor_load exactly once per op.
//   5 reset mid-op: reset at cor_addr=7 -> next cycle IDLE, out_valid=0, no result.
//   6 param: ITERS=4, ADDRW=2 -> cor_addr 0..3, out_valid at edge 6.

Source files
------------

// File: rtl/cordic_seq.sv
// Sequencer around a 16-bit iterative CORDIC datapath: accepts an angle,
// drives load/addr for one load plus ITERS iteration cycles, then holds the result.
module cordic_seq #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16,
    parameter int ADDRW = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_angle,
    output logic             in_ready,
    output logic [WIDTH-1:0] cor_endangle,
    output logic             cor_load,
    output logic [ADDRW-1:0] cor_addr,
    input  logic [WIDTH-1:0] cor_sin,
    input  logic [WIDTH-1:0] cor_cos,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sin,
    output logic [WIDTH-1:0] out_cos,
    input  logic             out_ready,
    output logic             busy
);

    // One extra counter bit so ITERS == 2**ADDRW reaches its last value without wrapping.
    localparam int CNTW = ADDRW + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITERS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_d;
    logic [WIDTH-1:0] endangle_q;
    logic             load_q;
    logic [ADDRW-1:0] addr_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sin_q;
    logic [WIDTH-1:0] out_cos_q;

    // Next iteration index.
    always_comb begin
        cnt_d = cnt_q + CNTW'(1);
    end

    // Operation FSM with all handshake and datapath-control outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            endangle_q  <= '0;
            load_q      <= 1'b0;
            addr_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sin_q   <= '0;
            out_cos_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= LOAD;
                        endangle_q <= in_angle;
                        load_q     <= 1'b1;
                        addr_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                LOAD: begin
                    state_q <= ITER;
                    cnt_q   <= '0;
                    load_q  <= 1'b0;
                    addr_q  <= '0;
                end
                ITER: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= CAPT;
                    end else begin
                        cnt_q  <= cnt_d;
                        addr_q <= cnt_d[ADDRW-1:0];
                    end
                end
                CAPT: begin
                    state_q     <= DONE;
                    out_sin_q   <= cor_sin;
                    out_cos_q   <= cor_cos;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    load_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign cor_endangle = endangle_q;
    assign cor_load     = load_q;
    assign cor_addr     = addr_q;
    assign out_valid    = out_valid_q;
    assign out_sin      = out_sin_q;
    assign out_cos      = out_cos_q;

endmodule
